// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and the future host loader.
package dmem_port_arbiter_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DEPTH  = 1024;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_HOST = 2'd2
  } gnt_src_e;

  typedef enum logic {
    CORE_PRI = 1'b0,
    HOST_PRI = 1'b1
  } arb_state_e;

  // Zero-extended compare so the check stays meaningful when ADDR_W can exceed DEPTH.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Core MEM-stage, host and memory-side signals of the data-memory arbiter.
interface dmem_port_arbiter_if
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) ();

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic              core_hold;
  logic              core_stall;
  logic              core_rvalid;
  logic [31:0]       core_rdata;

  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic              host_rvalid;
  logic [31:0]       host_rdata;
  logic              host_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_hold,
    output core_stall, core_rvalid, core_rdata,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata, host_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_hold,
    input  core_stall, core_rvalid, core_rdata,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata, host_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Priority FSM and saturating starvation counter: forces a host slot after
// STARVE_LIMIT consecutive host losses.
module dmem_starve_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic host_elig,
  input  logic host_lost,
  input  logic host_gnt,
  output logic host_pri
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  arb_state_e       state_r;
  arb_state_e       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= CORE_PRI;
      cnt_r   <= ZERO_C;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      CORE_PRI: begin
        if (host_gnt || !host_elig) begin
          cnt_s = ZERO_C;
        end else if (host_lost) begin
          if ((cnt_r + ONE_C) == LIMIT_C) begin
            state_s = HOST_PRI;
            cnt_s   = LIMIT_C;
          end else begin
            cnt_s = cnt_r + ONE_C;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      HOST_PRI: begin
        if (host_gnt || !host_elig) begin
          state_s = CORE_PRI;
          cnt_s   = ZERO_C;
        end else begin
          state_s = HOST_PRI;
        end
      end
      default: begin
        state_s = CORE_PRI;
        cnt_s   = ZERO_C;
      end
    endcase
  end

  assign host_pri = (state_r == HOST_PRI);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous single-port data memory between the core MEM stage
// and a host port; core has priority, host is guaranteed a slot.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DEPTH        = DMEM_DEPTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   bus
);

  gnt_src_e gnt_s;
  logic     core_elig_s;
  logic     host_elig_s;
  logic     host_oor_s;
  logic     host_mem_elig_s;
  logic     host_ready_s;
  logic     host_lost_s;
  logic     host_pri_s;
  logic     core_tag_r;
  logic     host_tag_r;
  logic     host_oor_rd_r;
  logic     host_err_r;

  // Grant decision; everything is gated off while reset is asserted.
  always_comb begin
    core_elig_s     = reset && bus.core_req && !bus.core_hold;
    host_elig_s     = reset && bus.host_valid;
    host_oor_s      = host_elig_s && !addr_in_range(32'(bus.host_addr), DEPTH);
    host_mem_elig_s = host_elig_s && !host_oor_s;
    if (core_elig_s && host_mem_elig_s) begin
      gnt_s = host_pri_s ? GNT_HOST : GNT_CORE;
    end else if (core_elig_s) begin
      gnt_s = GNT_CORE;
    end else if (host_mem_elig_s) begin
      gnt_s = GNT_HOST;
    end else begin
      gnt_s = GNT_NONE;
    end
    // An out-of-range host request is consumed without taking the memory slot.
    host_ready_s = host_oor_s || (gnt_s == GNT_HOST);
    host_lost_s  = host_elig_s && !host_ready_s;
  end

  // Memory port drive from the winning requester.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = 32'h0000_0000;
    case (gnt_s)
      GNT_CORE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.core_we;
        bus.mem_addr  = bus.core_addr;
        bus.mem_wdata = bus.core_wdata;
      end
      GNT_HOST: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.host_we;
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

  dmem_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .reset     (reset),
    .host_elig (host_elig_s),
    .host_lost (host_lost_s),
    .host_gnt  (host_ready_s),
    .host_pri  (host_pri_s)
  );

  // Read-return tags and out-of-range flags, consumed on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_tag_r    <= 1'b0;
      host_tag_r    <= 1'b0;
      host_oor_rd_r <= 1'b0;
      host_err_r    <= 1'b0;
    end else begin
      core_tag_r    <= (gnt_s == GNT_CORE) && !bus.core_we;
      host_tag_r    <= (gnt_s == GNT_HOST) && !bus.host_we;
      host_oor_rd_r <= host_oor_s && !bus.host_we;
      host_err_r    <= host_oor_s;
    end
  end

  assign bus.core_stall  = bus.core_req && (gnt_s != GNT_CORE);
  assign bus.host_ready  = host_ready_s;
  assign bus.core_rvalid = core_tag_r;
  assign bus.core_rdata  = core_tag_r ? bus.mem_rdata : 32'h0000_0000;
  assign bus.host_rvalid = host_tag_r || host_oor_rd_r;
  assign bus.host_rdata  = host_tag_r ? bus.mem_rdata : 32'h0000_0000;
  assign bus.host_err    = host_err_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios then random
// traffic against a transaction-level reference model.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int AW    = 11;
  localparam int DEPTH = 1024;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(AW)) bus ();

  dmem_port_arbiter #(
    .ADDR_W       (AW),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous single-port RAM behind the arbiter.
  logic [31:0] sram [0:1023];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr[9:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= sram[bus.mem_addr[9:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: expected memory contents, consecutive host losses,
  // and the responses due on the next cycle.
  logic [31:0] ref_mem [0:15];
  int          losses;
  bit          p_core_v;
  logic [31:0] p_core_d;
  bit          p_host_v;
  bit          p_host_err;
  logic [31:0] p_host_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input bit req, input bit we, input bit hold, input int addr, input logic [31:0] wd);
    bus.core_req   = req;
    bus.core_we    = we;
    bus.core_hold  = hold;
    bus.core_addr  = AW'(addr);
    bus.core_wdata = wd;
  endtask

  task automatic set_host(input bit valid, input bit we, input int addr, input logic [31:0] wd);
    bus.host_valid = valid;
    bus.host_we    = we;
    bus.host_addr  = AW'(addr);
    bus.host_wdata = wd;
  endtask

  task automatic model_clear();
    losses     = 0;
    p_core_v   = 1'b0;
    p_host_v   = 1'b0;
    p_host_err = 1'b0;
    p_core_d   = 32'h0;
    p_host_d   = 32'h0;
  endtask

  // One clock cycle: check outputs against the model, advance the model, clock.
  task automatic cycle(output bit acc);
    bit ce, hv, oor, hm, forced, cg, hw, hr;
    #2;
    ce     = bus.core_req && !bus.core_hold;
    hv     = bus.host_valid;
    oor    = hv && (int'(bus.host_addr) >= DEPTH);
    hm     = hv && !oor;
    forced = (losses >= LIMIT);
    cg     = ce && !(hm && forced);
    hw     = hm && (!ce || forced);
    hr     = oor || hw;

    chk("core_rvalid", 32'(bus.core_rvalid), 32'(p_core_v));
    chk("core_rdata",  bus.core_rdata, p_core_v ? p_core_d : 32'h0);
    chk("host_rvalid", 32'(bus.host_rvalid), 32'(p_host_v));
    chk("host_rdata",  bus.host_rdata, p_host_v ? p_host_d : 32'h0);
    chk("host_err",    32'(bus.host_err), 32'(p_host_err));
    chk("core_stall",  32'(bus.core_stall), 32'(bus.core_req && !cg));
    chk("host_ready",  32'(bus.host_ready), 32'(hr));
    chk("mem_en",      32'(bus.mem_en), 32'(cg || hw));
    if (cg) begin
      chk("mem_we_core",   32'(bus.mem_we), 32'(bus.core_we));
      chk("mem_addr_core", 32'(bus.mem_addr), 32'(bus.core_addr));
      if (bus.core_we) chk("mem_wdata_core", bus.mem_wdata, bus.core_wdata);
    end else if (hw) begin
      chk("mem_we_host",   32'(bus.mem_we), 32'(bus.host_we));
      chk("mem_addr_host", 32'(bus.mem_addr), 32'(bus.host_addr));
      if (bus.host_we) chk("mem_wdata_host", bus.mem_wdata, bus.host_wdata);
    end

    p_core_v   = cg && !bus.core_we;
    p_core_d   = ref_mem[bus.core_addr[3:0]];
    p_host_v   = hr && !bus.host_we;
    p_host_d   = (hw && !bus.host_we) ? ref_mem[bus.host_addr[3:0]] : 32'h0;
    p_host_err = oor;
    if (cg && bus.core_we) ref_mem[bus.core_addr[3:0]] = bus.core_wdata;
    if (hw && bus.host_we) ref_mem[bus.host_addr[3:0]] = bus.host_wdata;
    losses = (!hv || hr) ? 0 : losses + 1;
    acc    = hr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    set_core(1'b0, 1'b0, 1'b0, 0, 32'h0);
    set_host(1'b0, 1'b0, 0, 32'h0);
    #2;
    chk({tag, "_host_rvalid"}, 32'(bus.host_rvalid), 32'h0);
    chk({tag, "_core_rvalid"}, 32'(bus.core_rvalid), 32'h0);
    chk({tag, "_host_err"},    32'(bus.host_err), 32'h0);
    chk({tag, "_host_rdata"},  bus.host_rdata, 32'h0);
    chk({tag, "_core_rdata"},  bus.core_rdata, 32'h0);
    chk({tag, "_core_stall"},  32'(bus.core_stall), 32'h0);
    chk({tag, "_mem_en"},      32'(bus.mem_en), 32'h0);
    chk({tag, "_mem_we"},      32'(bus.mem_we), 32'h0);
    // Requests presented during reset must not be granted.
    set_host(1'b1, 1'b0, 2, 32'h0);
    #1;
    chk({tag, "_host_ready"},  32'(bus.host_ready), 32'h0);
    chk({tag, "_mem_en_req"},  32'(bus.mem_en), 32'h0);
    set_host(1'b0, 1'b0, 0, 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    chk({tag, "_host_rvalid2"}, 32'(bus.host_rvalid), 32'h0);
    reset = 1'b1;
  endtask

  task automatic starve_round(input string tag);
    int win_k;
    bit acc;
    win_k = -1;
    set_host(1'b1, 1'b0, 7, 32'h0);
    for (int k = 0; k < 8; k++) begin
      set_core(1'b1, 1'b0, 1'b0, k & 15, 32'h0);
      cycle(acc);
      if (acc && win_k < 0) begin
        win_k = k;
        set_host(1'b0, 1'b0, 0, 32'h0);
      end
    end
    chk(tag, 32'(win_k), 32'(LIMIT));
    set_core(1'b0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  initial begin
    bit acc;
    bit hold_req;
    reset = 1'b0;
    bus.mem_rdata = 32'h0;
    set_core(1'b0, 1'b0, 1'b0, 0, 32'h0);
    set_host(1'b0, 1'b0, 0, 32'h0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset_init");

    // Preload the 16-word working window through the host port.
    for (int i = 0; i < 16; i++) begin
      set_host(1'b1, 1'b1, i, (i == 5) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i)));
      cycle(acc);
    end
    set_host(1'b0, 1'b0, 0, 32'h0);

    // Core-only load.
    set_core(1'b1, 1'b0, 1'b0, 5, 32'h0);
    cycle(acc);
    chk("core_load_5", bus.core_rdata, 32'hDEAD_BEEF);
    set_core(1'b0, 1'b0, 1'b0, 0, 32'h0);
    cycle(acc);

    // Host write then read-back.
    set_host(1'b1, 1'b1, 3, 32'h1234_5678);
    cycle(acc);
    set_host(1'b1, 1'b0, 3, 32'h0);
    cycle(acc);
    chk("host_readback_3", bus.host_rdata, 32'h1234_5678);
    set_host(1'b0, 1'b0, 0, 32'h0);
    cycle(acc);

    // Starvation: two rounds, the second proving priority fell back.
    starve_round("starve_round1");
    starve_round("starve_round2");

    // Debug freeze, then release.
    set_core(1'b1, 1'b0, 1'b1, 2, 32'h0);
    repeat (3) cycle(acc);
    set_core(1'b1, 1'b0, 1'b0, 2, 32'h0);
    cycle(acc);
    set_core(1'b0, 1'b0, 1'b0, 0, 32'h0);
    cycle(acc);

    // Out-of-range host read alongside a core load, then out-of-range write.
    set_core(1'b1, 1'b0, 1'b0, 9, 32'h0);
    set_host(1'b1, 1'b0, 1024, 32'h0);
    cycle(acc);
    chk("oor_rd_err",    32'(bus.host_err), 32'h1);
    chk("oor_rd_rvalid", 32'(bus.host_rvalid), 32'h1);
    chk("oor_core_data", bus.core_rdata, 32'hC0DE_0009);
    set_core(1'b0, 1'b0, 1'b0, 0, 32'h0);
    set_host(1'b1, 1'b1, 1500, 32'hFFFF_FFFF);
    cycle(acc);
    set_host(1'b0, 1'b0, 0, 32'h0);
    cycle(acc);
    chk("oor_wr_no_rvalid", 32'(bus.host_rvalid), 32'h0);

    // Reset during contention, then with a host read in flight.
    set_core(1'b1, 1'b0, 1'b0, 1, 32'h0);
    set_host(1'b1, 1'b0, 4, 32'h0);
    repeat (2) cycle(acc);
    do_reset("reset_contention");
    starve_round("starve_after_reset");
    set_host(1'b1, 1'b0, 4, 32'h0);
    cycle(acc);
    do_reset("reset_pending");
    set_host(1'b0, 1'b0, 0, 32'h0);
    cycle(acc);

    // Random traffic; an unaccepted host request is held until accepted.
    hold_req = 1'b0;
    for (int n = 0; n < 600; n++) begin
      set_core(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 9) == 0), $urandom_range(0, 15), $urandom);
      if (!hold_req) begin
        if ($urandom_range(0, 9) < 6) begin
          set_host(1'b1, $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 9) == 0) ? (1024 + $urandom_range(0, 500)) : $urandom_range(0, 15),
                   $urandom);
        end else begin
          set_host(1'b0, 1'b0, 0, 32'h0);
        end
      end
      cycle(acc);
      hold_req = bus.host_valid && !acc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
